// File: rtl/midori_sbox_layer_ti.sv
// midori_sbox_layer_ti
// --------------------------------------------------------------------------
// Three-share threshold implementation of the full 64-bit Midori64 Sb0 layer.
// The shared state is processed NPAR nibbles per cycle, starting from the
// low bits. Each nibble goes through a two-stage shared S-box pipeline with
// one register between the two quadratic stages.
//
// Sb0 is cubic. It is split into two quadratic maps.
//   Stage 1: g = (x1, e0, e1, e2) with
//            e0 = x0x2 ^ x0x3 ^ x2x3
//            e1 = x0 ^ x3 ^ x0x3 ^ x2x3
//            e2 = x0 ^ x2
//   Stage 2: y0 = e0e1 ^ x1 ^ x1e0
//            y1 = e0 ^ e2
//            y2 = 1 ^ e0 ^ e1 ^ e0e1 ^ x1e0
//            y3 = 1 ^ e0 ^ e0e1 ^ x1e1
// Both stages use direct non-complete sharing. Output share i only sees
// input shares i+1 and i+2 (mod 3), so no share is ever recombined.
//
// Parameters:
//   NPAR        number of parallel shared S-boxes; legal values 1, 2, 4, 8, 16
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   start       request a layer pass; only sampled while idle
//   state_in1/2/3   three Boolean shares of the input state
//   busy        high while a pass is in progress
//   done        one-cycle pulse when state_out* holds the complete result
//   state_out1/2/3  three shares of the S-box layer output
module midori_sbox_layer_ti #(
    parameter int NPAR = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] state_in1,
    input  logic [63:0] state_in2,
    input  logic [63:0] state_in3,
    output logic        busy,
    output logic        done,
    output logic [63:0] state_out1,
    output logic [63:0] state_out2,
    output logic [63:0] state_out3
);

    localparam int NCHUNK = 16 / NPAR;
    localparam int W      = 4 * NPAR;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    generate
        if (!(NPAR == 1 || NPAR == 2 || NPAR == 4 || NPAR == 8 || NPAR == 16)) begin : g_bad_npar
            $error("midori_sbox_layer_ti: NPAR must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    // One output share of a shared AND: built from the (j, k) shares of a and b.
    function automatic logic mul_sh(input logic aj, input logic ak,
                                    input logic bj, input logic bk);
        return (aj & bj) ^ (aj & bk) ^ (ak & bj);
    endfunction

    // Stage-1 share from the two neighbouring input-nibble shares.
    // Result packing: {e2, e1, e0, x1}.
    function automatic logic [3:0] stage1_share(input logic [3:0] xj,
                                                input logic [3:0] xk);
        logic m02, m03, m23;
        logic e0, e1, e2;
        m02 = mul_sh(xj[0], xk[0], xj[2], xk[2]);
        m03 = mul_sh(xj[0], xk[0], xj[3], xk[3]);
        m23 = mul_sh(xj[2], xk[2], xj[3], xk[3]);
        e0  = m02 ^ m03 ^ m23;
        e1  = xj[0] ^ xj[3] ^ m03 ^ m23;
        e2  = xj[0] ^ xj[2];
        return {e2, e1, e0, xj[1]};
    endfunction

    // Stage-2 share from the two neighbouring stage-register shares.
    // The affine constant goes into exactly one share (add_one).
    function automatic logic [3:0] stage2_share(input logic [3:0] gj,
                                                input logic [3:0] gk,
                                                input logic       add_one);
        logic p_e0e1, p_x1e0, p_x1e1;
        logic [3:0] y;
        p_e0e1 = mul_sh(gj[1], gk[1], gj[2], gk[2]);
        p_x1e0 = mul_sh(gj[0], gk[0], gj[1], gk[1]);
        p_x1e1 = mul_sh(gj[0], gk[0], gj[2], gk[2]);
        y[0]   = p_e0e1 ^ gj[0] ^ p_x1e0;
        y[1]   = gj[1] ^ gj[3];
        y[2]   = add_one ^ gj[1] ^ gj[2] ^ p_e0e1 ^ p_x1e0;
        y[3]   = add_one ^ gj[1] ^ p_e0e1 ^ p_x1e1;
        return y;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] out_idx;
    logic          stg_valid;
    logic [63:0]   in1_q, in2_q, in3_q;
    logic [W-1:0]  stg1, stg2, stg3;
    logic [W-1:0]  chunk1, chunk2, chunk3;
    logic [W-1:0]  s1_res1, s1_res2, s1_res3;
    logic [W-1:0]  s2_res1, s2_res2, s2_res3;
    logic          load_in, feed;

    assign chunk1 = in1_q[cnt*W +: W];
    assign chunk2 = in2_q[cnt*W +: W];
    assign chunk3 = in3_q[cnt*W +: W];

    assign busy = (state_q != IDLE);

    // Both shared stages for all NPAR nibbles of the current chunk.
    always_comb begin
        s1_res1 = '0;
        s1_res2 = '0;
        s1_res3 = '0;
        s2_res1 = '0;
        s2_res2 = '0;
        s2_res3 = '0;
        for (int n = 0; n < NPAR; n++) begin
            s1_res1[4*n +: 4] = stage1_share(chunk2[4*n +: 4], chunk3[4*n +: 4]);
            s1_res2[4*n +: 4] = stage1_share(chunk3[4*n +: 4], chunk1[4*n +: 4]);
            s1_res3[4*n +: 4] = stage1_share(chunk1[4*n +: 4], chunk2[4*n +: 4]);
            s2_res1[4*n +: 4] = stage2_share(stg2[4*n +: 4], stg3[4*n +: 4], 1'b1);
            s2_res2[4*n +: 4] = stage2_share(stg3[4*n +: 4], stg1[4*n +: 4], 1'b0);
            s2_res3[4*n +: 4] = stage2_share(stg1[4*n +: 4], stg2[4*n +: 4], 1'b0);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. DRAIN always lasts exactly one cycle: it writes the
    // last chunk, which was loaded on the edge that entered DRAIN.
    always_comb begin
        state_d = state_q;
        load_in = 1'b0;
        feed    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_in = 1'b1;
                    state_d = FEED;
                end
            end
            FEED: begin
                feed = 1'b1;
                if (cnt == LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: input capture, stage register and per-chunk output writes.
    // out_idx trails cnt by one cycle so the write lands in the slice the
    // stage register came from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in1_q      <= '0;
            in2_q      <= '0;
            in3_q      <= '0;
            cnt        <= '0;
            out_idx    <= '0;
            stg_valid  <= 1'b0;
            stg1       <= '0;
            stg2       <= '0;
            stg3       <= '0;
            done       <= 1'b0;
            state_out1 <= '0;
            state_out2 <= '0;
            state_out3 <= '0;
        end else begin
            done      <= (state_q == DRAIN);
            stg_valid <= feed;
            if (load_in) begin
                in1_q <= state_in1;
                in2_q <= state_in2;
                in3_q <= state_in3;
                cnt   <= '0;
            end
            if (feed) begin
                stg1    <= s1_res1;
                stg2    <= s1_res2;
                stg3    <= s1_res3;
                out_idx <= cnt;
                cnt     <= (cnt == LAST) ? '0 : cnt + CW'(1);
            end
            if (stg_valid) begin
                state_out1[out_idx*W +: W] <= s2_res1;
                state_out2[out_idx*W +: W] <= s2_res2;
                state_out3[out_idx*W +: W] <= s2_res3;
            end
        end
    end

endmodule

// File: tb/tb_midori_sbox_layer_ti.sv
// tb_midori_sbox_layer_ti
// --------------------------------------------------------------------------
// Self-checking bench for midori_sbox_layer_ti. One instance per legal NPAR
// (1, 2, 4, 8, 16) shares the clock, reset, start and input shares; the
// NPAR=4 instance is the one driven through the directed handshake cases.
// Expected values come from a table-driven Sb0 layer model.
module tb_midori_sbox_layer_ti;

    localparam int NINST = 5;
    localparam int MAIN  = 2;
    localparam int NPV [NINST] = '{1, 2, 4, 8, 16};

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] state_in1, state_in2, state_in3;
    logic        busy_v [NINST];
    logic        done_v [NINST];
    logic [63:0] out1_v [NINST];
    logic [63:0] out2_v [NINST];
    logic [63:0] out3_v [NINST];

    int n_checks = 0;
    int n_fails  = 0;
    int lat        [NINST];
    int dcount     [NINST];
    int busy_first [NINST];
    int busy_last  [NINST];

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        midori_sbox_layer_ti #(.NPAR(NPV[g])) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .state_in1  (state_in1),
            .state_in2  (state_in2),
            .state_in3  (state_in3),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .state_out1 (out1_v[g]),
            .state_out2 (out2_v[g]),
            .state_out3 (out3_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unshared reference: Sb0 table applied to every nibble.
    function automatic logic [63:0] sb_layer(input logic [63:0] x);
        logic [3:0] tbl [16];
        logic [63:0] y;
        tbl = '{4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
                4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = tbl[x[4*n +: 4]];
        end
        return y;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkNotEqual(input string tag, input logic [63:0] obs, input logic [63:0] bad);
        n_checks++;
        assert (obs !== bad) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h must differ from %h", tag, obs, bad);
        end
    endtask

    // One pass with masked input x; watches every instance for 24 cycles and
    // records done latency, done pulse count and busy window (cycle c is the
    // negedge after the c-th rising edge, edge 0 being the one sampling start).
    task automatic applyStimulus(input logic [63:0] x, input logic [63:0] m1, input logic [63:0] m2);
        @(negedge clk);
        state_in1 = x ^ m1 ^ m2;
        state_in2 = m1;
        state_in3 = m2;
        start     = 1'b1;
        for (int g = 0; g < NINST; g++) begin
            lat[g] = -1; dcount[g] = 0; busy_first[g] = -1; busy_last[g] = -1;
        end
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            start = 1'b0;
            for (int g = 0; g < NINST; g++) begin
                if (done_v[g] === 1'b1) begin
                    dcount[g]++;
                    if (lat[g] < 0) lat[g] = c;
                end
                if (busy_v[g] === 1'b1) begin
                    if (busy_first[g] < 0) busy_first[g] = c;
                    busy_last[g] = c;
                end
            end
        end
    endtask

    task automatic checkPass(input int g, input string tag, input logic [63:0] exp_y);
        checkOutput($sformatf("%s_lat_np%0d", tag, NPV[g]), 64'(lat[g]), 64'(16 / NPV[g] + 1));
        checkOutput($sformatf("%s_ndone_np%0d", tag, NPV[g]), 64'(dcount[g]), 64'd1);
        checkOutput($sformatf("%s_xor_np%0d", tag, NPV[g]),
                    out1_v[g] ^ out2_v[g] ^ out3_v[g], exp_y);
    endtask

    initial begin
        logic [63:0] x, xa, xb, m1, m2, y;
        int first, second, nd;

        rst = 1'b1; start = 1'b0;
        state_in1 = '0; state_in2 = '0; state_in3 = '0;
        repeat (2) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_busy", 64'(busy_v[MAIN]), 64'd0);
        checkOutput("rst_done", 64'(done_v[MAIN]), 64'd0);
        checkOutput("rst_out1", out1_v[MAIN], 64'd0);
        checkOutput("rst_out2", out2_v[MAIN], 64'd0);
        checkOutput("rst_out3", out3_v[MAIN], 64'd0);
        rst = 1'b0;

        $display("[TB] zero state");
        applyStimulus(64'd0, 64'd0, 64'd0);
        checkPass(MAIN, "zero", 64'hCCCC_CCCC_CCCC_CCCC);
        checkOutput("zero_busy_first", 64'(busy_first[MAIN]), 64'd0);
        checkOutput("zero_busy_last", 64'(busy_last[MAIN]), 64'd4);

        $display("[TB] counting state on every NPAR");
        applyStimulus(64'h0123_4567_89AB_CDEF, rand64(), rand64());
        for (int g = 0; g < NINST; g++) begin
            checkPass(g, "count", 64'hCAD3_EBF7_8915_0246);
        end

        $display("[TB] involution back-to-back");
        x = 64'h0123_4567_89AB_CDEF; m1 = rand64(); m2 = rand64();
        @(negedge clk);
        state_in1 = x ^ m1 ^ m2; state_in2 = m1; state_in3 = m2; start = 1'b1;
        first = -1; second = -1;
        for (int c = 0; c < 40 && second < 0; c++) begin
            @(negedge clk);
            if (done_v[MAIN] === 1'b1) begin
                if (first < 0) begin
                    first = c;
                    checkOutput("inv_pass1", out1_v[MAIN] ^ out2_v[MAIN] ^ out3_v[MAIN], sb_layer(x));
                    state_in1 = out1_v[MAIN]; state_in2 = out2_v[MAIN]; state_in3 = out3_v[MAIN];
                end else begin
                    second = c;
                    checkOutput("inv_pass2", out1_v[MAIN] ^ out2_v[MAIN] ^ out3_v[MAIN], x);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checkOutput("inv_lat", 64'(first), 64'd5);
        checkOutput("inv_spacing", 64'(second - first), 64'd6);
        repeat (24) @(negedge clk);

        $display("[TB] start ignored while busy");
        xa = rand64(); xb = ~xa; m1 = rand64(); m2 = rand64();
        @(negedge clk);
        state_in1 = xa ^ m1 ^ m2; state_in2 = m1; state_in3 = m2; start = 1'b1;
        first = -1; nd = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            start = (c == 2);
            if (c == 2) begin
                state_in1 = xb; state_in2 = rand64(); state_in3 = rand64();
            end
            if (done_v[MAIN] === 1'b1) begin
                nd++;
                if (first < 0) first = c;
            end
        end
        checkOutput("ign_ndone", 64'(nd), 64'd1);
        checkOutput("ign_lat", 64'(first), 64'd5);
        checkOutput("ign_xor", out1_v[MAIN] ^ out2_v[MAIN] ^ out3_v[MAIN], sb_layer(xa));

        $display("[TB] reset abort");
        @(negedge clk);
        state_in1 = rand64(); state_in2 = rand64(); state_in3 = rand64(); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_busy", 64'(busy_v[MAIN]), 64'd0);
        checkOutput("abort_done", 64'(done_v[MAIN]), 64'd0);
        checkOutput("abort_out1", out1_v[MAIN], 64'd0);
        checkOutput("abort_out2", out2_v[MAIN], 64'd0);
        checkOutput("abort_out3", out3_v[MAIN], 64'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (done_v[MAIN] === 1'b1) nd++;
        end
        checkOutput("abort_ndone", 64'(nd), 64'd0);
        checkOutput("abort_out_hold", out1_v[MAIN] | out2_v[MAIN] | out3_v[MAIN], 64'd0);
        x = rand64();
        applyStimulus(x, rand64(), rand64());
        checkPass(MAIN, "after_abort", sb_layer(x));

        $display("[TB] random shared states");
        for (int i = 0; i < 1000; i++) begin
            x = rand64(); m1 = rand64(); m2 = rand64();
            y = sb_layer(x);
            applyStimulus(x, m1, m2);
            for (int g = 0; g < NINST; g++) begin
                checkPass(g, "rnd", y);
                if (m1 != 64'd0 || m2 != 64'd0) begin
                    checkNotEqual($sformatf("rnd_share1_np%0d", NPV[g]), out1_v[g], y);
                    checkNotEqual($sformatf("rnd_share2_np%0d", NPV[g]), out2_v[g], y);
                    checkNotEqual($sformatf("rnd_share3_np%0d", NPV[g]), out3_v[g], y);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
